// File: rtl/div_ctrl.sv
// Sequencer for the shared signed/unsigned AXI-Stream divider IPs used by EX.
// Optional DIV_ZERO_BYPASS_EN: zero divisors complete locally without touching an IP.
module div_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        cancel,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        busy,
   output logic [31:0] div_dividend_tdata,
   output logic [31:0] div_divisor_tdata,
   output logic        sdiv_dividend_tvalid,
   input  logic        sdiv_dividend_tready,
   output logic        sdiv_divisor_tvalid,
   input  logic        sdiv_divisor_tready,
   input  logic        sdiv_dout_tvalid,
   input  logic [63:0] sdiv_dout_tdata,
   output logic        udiv_dividend_tvalid,
   input  logic        udiv_dividend_tready,
   output logic        udiv_divisor_tvalid,
   input  logic        udiv_divisor_tready,
   input  logic        udiv_dout_tvalid,
   input  logic [63:0] udiv_dout_tdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   function automatic logic is_onehot4(input logic [3:0] v);
      is_onehot4 = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   state_t      state_r, state_nxt_s;
   logic [3:0]  op_r, op_nxt_s;
   logic [31:0] dividend_r, dividend_nxt_s;
   logic [31:0] divisor_r, divisor_nxt_s;
   logic [31:0] result_r, result_nxt_s;
   logic        sdvd_vld_r, sdvs_vld_r, udvd_vld_r, udvs_vld_r;
   logic        sdvd_vld_nxt_s, sdvs_vld_nxt_s, udvd_vld_nxt_s, udvs_vld_nxt_s;
   logic        pend_r, pend_nxt_s;
   logic        busy_r, resp_valid_r;
   logic        sel_dout_vld_s;
   logic [63:0] sel_dout_data_s;
   logic [31:0] sel_result_s;
   logic        zero_bypass_s;
   logic [31:0] bypass_result_s;

`ifdef DIV_ZERO_BYPASS_EN
   assign zero_bypass_s = (req_src2 == 32'd0);
`else
   assign zero_bypass_s = 1'b0;
`endif
   assign bypass_result_s = (req_op[1] | req_op[3]) ? req_src1 : 32'hFFFF_FFFF;

   assign req_ready            = (state_r == ST_IDLE) && !cancel;
   assign busy                 = busy_r;
   assign resp_valid           = resp_valid_r;
   assign resp_result          = result_r;
   assign div_dividend_tdata   = dividend_r;
   assign div_divisor_tdata    = divisor_r;
   assign sdiv_dividend_tvalid = sdvd_vld_r;
   assign sdiv_divisor_tvalid  = sdvs_vld_r;
   assign udiv_dividend_tvalid = udvd_vld_r;
   assign udiv_divisor_tvalid  = udvs_vld_r;

   // Route the result channel of whichever IP the latched op selected.
   always_comb begin
      sel_dout_vld_s  = 1'b0;
      sel_dout_data_s = 64'd0;
      if (op_r[1:0] != 2'd0) begin
         sel_dout_vld_s  = sdiv_dout_tvalid;
         sel_dout_data_s = sdiv_dout_tdata;
      end else if (op_r[3:2] != 2'd0) begin
         sel_dout_vld_s  = udiv_dout_tvalid;
         sel_dout_data_s = udiv_dout_tdata;
      end else begin
         sel_dout_vld_s  = 1'b0;
         sel_dout_data_s = 64'd0;
      end
      sel_result_s = (op_r[1] | op_r[3]) ? sel_dout_data_s[31:0] : sel_dout_data_s[63:32];
   end

   // Next-state and datapath update; tvalids self-clear on their own handshake.
   always_comb begin
      state_nxt_s    = state_r;
      op_nxt_s       = op_r;
      dividend_nxt_s = dividend_r;
      divisor_nxt_s  = divisor_r;
      result_nxt_s   = result_r;
      pend_nxt_s     = pend_r;
      sdvd_vld_nxt_s = sdvd_vld_r & ~sdiv_dividend_tready;
      sdvs_vld_nxt_s = sdvs_vld_r & ~sdiv_divisor_tready;
      udvd_vld_nxt_s = udvd_vld_r & ~udiv_dividend_tready;
      udvs_vld_nxt_s = udvs_vld_r & ~udiv_divisor_tready;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && !cancel) begin
               op_nxt_s       = req_op;
               dividend_nxt_s = req_src1;
               divisor_nxt_s  = req_src2;
               pend_nxt_s     = 1'b0;
               if (!is_onehot4(req_op)) begin
                  result_nxt_s = 32'd0;
                  state_nxt_s  = ST_DONE;
               end else if (zero_bypass_s) begin
                  result_nxt_s = bypass_result_s;
                  state_nxt_s  = ST_DONE;
               end else begin
                  sdvd_vld_nxt_s = (req_op[1:0] != 2'd0);
                  sdvs_vld_nxt_s = (req_op[1:0] != 2'd0);
                  udvd_vld_nxt_s = (req_op[3:2] != 2'd0);
                  udvs_vld_nxt_s = (req_op[3:2] != 2'd0);
                  state_nxt_s    = ST_SEND;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            pend_nxt_s = pend_r | cancel;
            if (!(sdvd_vld_nxt_s | sdvs_vld_nxt_s | udvd_vld_nxt_s | udvs_vld_nxt_s)) begin
               state_nxt_s = pend_nxt_s ? ST_DRAIN : ST_WAIT;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_WAIT: begin
            // A cancel coinciding with the result pulse has nothing left to drain.
            if (cancel) begin
               state_nxt_s = sel_dout_vld_s ? ST_IDLE : ST_DRAIN;
            end else if (sel_dout_vld_s) begin
               result_nxt_s = sel_result_s;
               state_nxt_s  = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (cancel || resp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (sel_dout_vld_s) begin
               pend_nxt_s  = 1'b0;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand, result and handshake registers; status flags follow the next state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_r         <= 4'd0;
         dividend_r   <= 32'd0;
         divisor_r    <= 32'd0;
         result_r     <= 32'd0;
         pend_r       <= 1'b0;
         sdvd_vld_r   <= 1'b0;
         sdvs_vld_r   <= 1'b0;
         udvd_vld_r   <= 1'b0;
         udvs_vld_r   <= 1'b0;
         busy_r       <= 1'b0;
         resp_valid_r <= 1'b0;
      end else begin
         op_r         <= op_nxt_s;
         dividend_r   <= dividend_nxt_s;
         divisor_r    <= divisor_nxt_s;
         result_r     <= result_nxt_s;
         pend_r       <= pend_nxt_s;
         sdvd_vld_r   <= sdvd_vld_nxt_s;
         sdvs_vld_r   <= sdvs_vld_nxt_s;
         udvd_vld_r   <= udvd_vld_nxt_s;
         udvs_vld_r   <= udvs_vld_nxt_s;
         busy_r       <= (state_nxt_s != ST_IDLE);
         resp_valid_r <= (state_nxt_s == ST_DONE);
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the bench plays both divider IPs and
// supplies hand-computed quotient/remainder words.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_src1, req_src2;
   logic        cancel;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_result;
   logic        busy;
   logic [31:0] div_dividend_tdata, div_divisor_tdata;
   logic        sdiv_dividend_tvalid, sdiv_dividend_tready;
   logic        sdiv_divisor_tvalid, sdiv_divisor_tready;
   logic        sdiv_dout_tvalid;
   logic [63:0] sdiv_dout_tdata;
   logic        udiv_dividend_tvalid, udiv_dividend_tready;
   logic        udiv_divisor_tvalid, udiv_divisor_tready;
   logic        udiv_dout_tvalid;
   logic [63:0] udiv_dout_tdata;
   logic [3:0]  tv;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_dvd  = 0;
   int hs_dvs  = 0;
   int base_dvd, base_dvs;

   always #5 clk = ~clk;

   assign tv = {sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid};

   div_ctrl dut (
      .clk                  (clk),
      .resetn               (resetn),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_op               (req_op),
      .req_src1             (req_src1),
      .req_src2             (req_src2),
      .cancel               (cancel),
      .resp_valid           (resp_valid),
      .resp_ready           (resp_ready),
      .resp_result          (resp_result),
      .busy                 (busy),
      .div_dividend_tdata   (div_dividend_tdata),
      .div_divisor_tdata    (div_divisor_tdata),
      .sdiv_dividend_tvalid (sdiv_dividend_tvalid),
      .sdiv_dividend_tready (sdiv_dividend_tready),
      .sdiv_divisor_tvalid  (sdiv_divisor_tvalid),
      .sdiv_divisor_tready  (sdiv_divisor_tready),
      .sdiv_dout_tvalid     (sdiv_dout_tvalid),
      .sdiv_dout_tdata      (sdiv_dout_tdata),
      .udiv_dividend_tvalid (udiv_dividend_tvalid),
      .udiv_dividend_tready (udiv_dividend_tready),
      .udiv_divisor_tvalid  (udiv_divisor_tvalid),
      .udiv_divisor_tready  (udiv_divisor_tready),
      .udiv_dout_tvalid     (udiv_dout_tvalid),
      .udiv_dout_tdata      (udiv_dout_tdata)
   );

   // Count signed-channel transfers to prove exactly one per request.
   always @(posedge clk) begin
      if (sdiv_dividend_tvalid && sdiv_dividend_tready) hs_dvd <= hs_dvd + 1;
      if (sdiv_divisor_tvalid && sdiv_divisor_tready) hs_dvs <= hs_dvs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      #1 chk("req_ready_accept", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pulse(input logic sgn, input logic [63:0] d);
      if (sgn) begin
         sdiv_dout_tvalid = 1'b1;
         sdiv_dout_tdata  = d;
      end else begin
         udiv_dout_tvalid = 1'b1;
         udiv_dout_tdata  = d;
      end
      @(negedge clk);
      sdiv_dout_tvalid = 1'b0;
      udiv_dout_tvalid = 1'b0;
   endtask

   task automatic consume(input logic [31:0] exp);
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_result", resp_result, exp);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_valid_after", {31'd0, resp_valid}, 32'd0);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("req_ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] d, input logic [31:0] exp);
      accept(op, a, b);
      chk("busy_issue", {31'd0, busy}, 32'd1);
      chk("tvalid_issue", {28'd0, tv}, sgn ? 32'hC : 32'h3);
      chk("dividend_tdata", div_dividend_tdata, a);
      chk("divisor_tdata", div_divisor_tdata, b);
      @(negedge clk);
      chk("tvalid_wait", {28'd0, tv}, 32'd0);
      pulse(!sgn, 64'hDEAD_BEEF_0BAD_F00D);
      chk("ignore_other_ip", {31'd0, resp_valid}, 32'd0);
      pulse(sgn, d);
      consume(exp);
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_src1 = 32'd0; req_src2 = 32'd0;
      cancel = 1'b0; resp_ready = 1'b0;
      sdiv_dividend_tready = 1'b1; sdiv_divisor_tready = 1'b1;
      udiv_dividend_tready = 1'b1; udiv_divisor_tready = 1'b1;
      sdiv_dout_tvalid = 1'b0; sdiv_dout_tdata = 64'd0;
      udiv_dout_tvalid = 1'b0; udiv_dout_tdata = 64'd0;

      // Reset values
      #12;
      chk("rst_tvalid", {28'd0, tv}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_result", resp_result, 32'd0);
      chk("rst_tdata", div_dividend_tdata | div_divisor_tdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      cancel = 1'b1;
      #1 chk("rst_req_ready_cancel", {31'd0, req_ready}, 32'd0);
      cancel = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      // Basic signed and unsigned operations
      run_op(4'b0001, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 32'hFFFF_FFFD);
      run_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 32'hFFFF_FFFF);
      run_op(4'b0100, 32'hFFFF_FFFE, 32'd2, 1'b0, {32'h7FFF_FFFF, 32'h0}, 32'h7FFF_FFFF);
      run_op(4'b1000, 32'd100, 32'd7, 1'b0, {32'd14, 32'd2}, 32'd2);

      // Zero divisor
`ifdef DIV_ZERO_BYPASS_EN
      accept(4'b0001, 32'd5, 32'd0);
      chk("bypass_tvalid", {28'd0, tv}, 32'd0);
      consume(32'hFFFF_FFFF);
      accept(4'b1000, 32'd5, 32'd0);
      chk("bypass_tvalid_mod", {28'd0, tv}, 32'd0);
      consume(32'd5);
`else
      run_op(4'b0001, 32'd5, 32'd0, 1'b1, {32'hFFFF_FFFF, 32'd5}, 32'hFFFF_FFFF);
`endif

      // Non-one-hot op completes with 0 and no IP traffic
      accept(4'b0011, 32'd7, 32'd3);
      chk("bad_op_tvalid", {28'd0, tv}, 32'd0);
      consume(32'd0);

      // Cancel in IDLE blocks acceptance
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'b0001; cancel = 1'b1;
      #1 chk("req_ready_cancel", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0; cancel = 1'b0;
      chk("idle_cancel_busy", {31'd0, busy}, 32'd0);
      chk("idle_cancel_tvalid", {28'd0, tv}, 32'd0);

      // Staggered divisor ready
      sdiv_divisor_tready = 1'b0;
      base_dvd = hs_dvd; base_dvs = hs_dvs;
      accept(4'b0001, 32'd20, 32'd6);
      chk("stag_t1", {28'd0, tv}, 32'hC);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         if (i == 4) sdiv_divisor_tready = 1'b1;
         chk("stag_hold_tvalid", {28'd0, tv}, 32'h4);
         chk("stag_hold_tdata", div_divisor_tdata, 32'd6);
      end
      @(negedge clk);
      chk("stag_t5_tvalid", {28'd0, tv}, 32'd0);
      chk("stag_hs_dvd", hs_dvd - base_dvd, 32'd1);
      chk("stag_hs_dvs", hs_dvs - base_dvs, 32'd1);
      chk("stag_t5_busy", {31'd0, busy}, 32'd1);
      pulse(1'b1, {32'd3, 32'd2});
      consume(32'd3);

      // Cancel in WAIT
      accept(4'b0001, 32'd100, 32'd7);
      @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("drain_busy", {31'd0, busy}, 32'd1);
         chk("drain_resp_valid", {31'd0, resp_valid}, 32'd0);
         @(negedge clk);
      end
      pulse(1'b1, {32'd14, 32'd2});
      chk("drain_done_busy", {31'd0, busy}, 32'd0);
      chk("drain_done_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("drain_done_req_ready", {31'd0, req_ready}, 32'd1);
      run_op(4'b0001, 32'd9, 32'd3, 1'b1, {32'd3, 32'd0}, 32'd3);

      // Cancel in SEND: handshakes finish, result drained
      sdiv_divisor_tready = 1'b0;
      accept(4'b0001, 32'd8, 32'd2);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      sdiv_divisor_tready = 1'b1;
      chk("send_cancel_tvalid", {28'd0, tv}, 32'h4);
      @(negedge clk);
      chk("send_cancel_drain_tvalid", {28'd0, tv}, 32'd0);
      chk("send_cancel_busy", {31'd0, busy}, 32'd1);
      pulse(1'b1, {32'd4, 32'd0});
      chk("send_cancel_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("send_cancel_idle", {31'd0, busy}, 32'd0);

      // Backpressure in DONE
      accept(4'b0010, 32'hFFFF_FFF9, 32'd2);
      @(negedge clk);
      pulse(1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_resp_result", resp_result, 32'hFFFF_FFFF);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      consume(32'hFFFF_FFFF);

      // Cancel in DONE drops the result
      accept(4'b0100, 32'd9, 32'd2);
      @(negedge clk);
      pulse(1'b0, {32'd4, 32'd1});
      chk("done_cancel_pre", {31'd0, resp_valid}, 32'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("done_cancel_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("done_cancel_busy", {31'd0, busy}, 32'd0);

      // Reset mid-operation
      sdiv_divisor_tready = 1'b0;
      accept(4'b0001, 32'd50, 32'd5);
      chk("rst_mid_pre", {28'd0, tv}, 32'hC);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_tvalid", {28'd0, tv}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_tdata", div_dividend_tdata, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      sdiv_divisor_tready = 1'b1;
      pulse(1'b1, {32'd10, 32'd0});
      chk("rst_late_dout_busy", {31'd0, busy}, 32'd0);
      chk("rst_late_dout_valid", {31'd0, resp_valid}, 32'd0);
      run_op(4'b0100, 32'd50, 32'd5, 1'b0, {32'd10, 32'd0}, 32'd10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
